// File: rtl/sm_pkg.sv
// Shared constants for the SM PIO counter bank: read-select codes,
// status-word bit positions and the default counter width.
package sm_pkg;

  localparam int unsigned SM_CNT_W_DEF = 32;

  // Read-word select codes driven by the MCU on sm_mux
  typedef enum logic [1:0] {
    SM_SEL_CH0  = 2'd0,
    SM_SEL_CH1  = 2'd1,
    SM_SEL_REF  = 2'd2,
    SM_SEL_STAT = 2'd3
  } sm_sel_e;

  // Status word low-bit positions; snap_cnt occupies the top SNAP_W bits
  localparam int unsigned SM_ST_OVF0   = 0;
  localparam int unsigned SM_ST_OVF1   = 1;
  localparam int unsigned SM_ST_OVFREF = 2;
  localparam int unsigned SM_ST_ENA    = 3;

endpackage

// File: rtl/sm_sync_edge.sv
// Multi-flop synchroniser for WIDTH asynchronous lines, with a registered
// previous value per line for rising-edge detection.
module sm_sync_edge #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;
  logic [STAGES:0]              r_prime;

  // Shift the pins through the synchroniser; r_prime fills with ones so the
  // edge detector only trusts r_prev once it holds a genuinely sampled pin
  // value (a line already high at reset release is not an edge).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_prev  <= '0;
      r_prime <= '0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_async};
      r_prev  <= r_sync[STAGES-1];
      r_prime <= {r_prime[STAGES-1:0], 1'b1};
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_prev & {WIDTH{r_prime[STAGES]}};

endmodule

// File: rtl/sm_counter_bank.sv
// Gated edge/reference counters with strobe-triggered shadow snapshot and
// a registered read mux for the MCU's SM PIO group.
module sm_counter_bank
  import sm_pkg::*;
#(
  parameter int unsigned CNT_W       = SM_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SNAP_W      = 8
) (
  input  logic             clk_in_clk,
  input  logic             reset_in_reset_n,
  input  logic [1:0]       sig_in,
  input  logic             sm_1clr,
  input  logic             sm_1ena,
  input  logic             sm_2strobe,
  input  logic [1:0]       sm_mux,
  output logic [CNT_W-1:0] sm_data_out,
  output logic             sm_irq
);

  logic [1:0]       w_sig_s;
  logic [1:0]       w_sig_rise;
  logic             w_clr_s;
  logic             w_clr_rise;
  logic             w_ena_s;
  logic             w_ena_rise;
  logic             w_stb_s;
  logic             w_stb_rise;
  logic             w_unused_sync;

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_cntref;
  logic             r_ovf0;
  logic             r_ovf1;
  logic             r_ovfref;

  logic [CNT_W-1:0] r_sh0;
  logic [CNT_W-1:0] r_sh1;
  logic [CNT_W-1:0] r_shref;
  logic [2:0]       r_shovf;
  logic [SNAP_W-1:0] r_snap_cnt;

  logic             r_snap_d;
  logic             r_irq;
  logic [CNT_W-1:0] r_data;
  logic [CNT_W-1:0] w_status;
  logic [CNT_W-1:0] w_rd_word;

  sm_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_sig (
    .i_clk(clk_in_clk), .i_rst_n(reset_in_reset_n), .i_async(sig_in),
    .o_sync(w_sig_s), .o_rise(w_sig_rise)
  );
  sm_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clr (
    .i_clk(clk_in_clk), .i_rst_n(reset_in_reset_n), .i_async(sm_1clr),
    .o_sync(w_clr_s), .o_rise(w_clr_rise)
  );
  sm_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ena (
    .i_clk(clk_in_clk), .i_rst_n(reset_in_reset_n), .i_async(sm_1ena),
    .o_sync(w_ena_s), .o_rise(w_ena_rise)
  );
  sm_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_stb (
    .i_clk(clk_in_clk), .i_rst_n(reset_in_reset_n), .i_async(sm_2strobe),
    .o_sync(w_stb_s), .o_rise(w_stb_rise)
  );

  // Level lines only need their synced value; edge lines only their pulse
  assign w_unused_sync = ^{w_sig_s, w_clr_rise, w_ena_rise, w_stb_s};

  // Live counters: clear beats enable; saturate at all-ones with sticky ovf
  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_cntref <= '0;
      r_ovf0   <= 1'b0;
      r_ovf1   <= 1'b0;
      r_ovfref <= 1'b0;
    end else if (w_clr_s) begin
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_cntref <= '0;
      r_ovf0   <= 1'b0;
      r_ovf1   <= 1'b0;
      r_ovfref <= 1'b0;
    end else if (w_ena_s) begin
      if (w_sig_rise[0]) begin
        if (r_cnt0 == '1) r_ovf0 <= 1'b1;
        else              r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_sig_rise[1]) begin
        if (r_cnt1 == '1) r_ovf1 <= 1'b1;
        else              r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
      if (r_cntref == '1) r_ovfref <= 1'b1;
      else                r_cntref <= r_cntref + CNT_W'(1);
    end
  end

  // Snapshot the pre-update live state on each synced strobe rise
  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_sh0      <= '0;
      r_sh1      <= '0;
      r_shref    <= '0;
      r_shovf    <= '0;
      r_snap_cnt <= '0;
    end else if (w_stb_rise) begin
      r_sh0      <= r_cnt0;
      r_sh1      <= r_cnt1;
      r_shref    <= r_cntref;
      r_shovf    <= {r_ovfref, r_ovf1, r_ovf0};
      r_snap_cnt <= r_snap_cnt + SNAP_W'(1);
    end
  end

  // Assemble the status word and select the word to present
  always_comb begin
    w_status                      = '0;
    w_status[CNT_W-1 -: SNAP_W]   = r_snap_cnt;
    w_status[SM_ST_ENA]           = w_ena_s;
    w_status[SM_ST_OVFREF]        = r_shovf[2];
    w_status[SM_ST_OVF1]          = r_shovf[1];
    w_status[SM_ST_OVF0]          = r_shovf[0];
    w_rd_word                     = '0;
    case (sm_sel_e'(sm_mux))
      SM_SEL_CH0:  w_rd_word = r_sh0;
      SM_SEL_CH1:  w_rd_word = r_sh1;
      SM_SEL_REF:  w_rd_word = r_shref;
      SM_SEL_STAT: w_rd_word = w_status;
      default:     w_rd_word = '0;
    endcase
  end

  // Registered read port; irq is delayed so it lines up with the first
  // cycle sm_data_out carries the freshly loaded shadows
  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_data   <= '0;
      r_snap_d <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_data   <= w_rd_word;
      r_snap_d <= w_stb_rise;
      r_irq    <= r_snap_d;
    end
  end

  assign sm_data_out = r_data;
  assign sm_irq      = r_irq;

endmodule
